// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle for the decode stage.
// The stage itself uses the slave modport; the fetch/issue environment uses master.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_op;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [9:0]  out_func;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_func, out_imm, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_func, out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV32M decode stage: combinational decode of the fetched word into a
// record, buffered in a small FIFO, with saturating accepted/illegal counters.
module decode_stage #(
    parameter bit EN_M  = 1'b1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] cnt_instr,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  func;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] cnt_instr_q, cnt_instr_d;
    logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;

    rec_t        dec;
    logic        legal;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        full;
    logic        push;
    logic        pop;

    assign instr = bus.in_instr;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    // Any word with instr[1:0] != 2'b11 misses every case item and lands in default.
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opc)
            OP_R: begin
                dec.rs1  = instr[19:15];
                dec.rs2  = instr[24:20];
                dec.rd   = instr[11:7];
                dec.func = {f7, f3};
                legal    = (f7 == 7'b0000000)
                        || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                        || (f7 == 7'b0000001 && EN_M);
            end
            OP_IMM: begin
                dec.rs1 = instr[19:15];
                dec.rd  = instr[11:7];
                dec.imm = {{20{instr[31]}}, instr[31:20]};
                if (f3 == 3'b001) begin
                    dec.func = {f7, f3};
                    legal    = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.func = {f7, f3};
                    legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end else begin
                    dec.func = {7'b0, f3};
                    legal    = 1'b1;
                end
            end
            OP_LOAD, OP_JALR: begin
                dec.rs1  = instr[19:15];
                dec.rd   = instr[11:7];
                dec.func = {7'b0, f3};
                dec.imm  = {{20{instr[31]}}, instr[31:20]};
                if (opc == OP_JALR) legal = (f3 == 3'b000);
                else                legal = (f3 != 3'b011) && (f3 <= 3'b101);
            end
            OP_STORE: begin
                dec.rs1  = instr[19:15];
                dec.rs2  = instr[24:20];
                dec.func = {7'b0, f3};
                dec.imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                legal    = (f3 <= 3'b010);
            end
            OP_BRANCH: begin
                dec.rs1  = instr[19:15];
                dec.rs2  = instr[24:20];
                dec.func = {7'b0, f3};
                dec.imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
                legal    = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_LUI, OP_AUIPC: begin
                dec.rd  = instr[11:7];
                dec.imm = {instr[31:12], 12'b0};
                legal   = 1'b1;
            end
            OP_JAL: begin
                dec.rd  = instr[11:7];
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) dec = '0;
        dec.op      = opc;
        dec.pc      = bus.in_pc;
        dec.illegal = ~legal;
    end

    // in_ready is built from registered state and flush only, never from out_ready.
    assign full         = (count_q == CW'(DEPTH));
    assign bus.in_ready = rdy_q & ~full & ~flush;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_valid & bus.out_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdy_d       = 1'b1;
        cnt_instr_d = cnt_instr_q;
        cnt_ill_d   = cnt_ill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (push && !(&cnt_instr_q)) cnt_instr_d = cnt_instr_q + CNT_W'(1);
        if (push && dec.illegal && !(&cnt_ill_q)) cnt_ill_d = cnt_ill_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdy_q       <= 1'b0;
            cnt_instr_q <= '0;
            cnt_ill_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdy_q       <= rdy_d;
            cnt_instr_q <= cnt_instr_d;
            cnt_ill_q   <= cnt_ill_d;
        end
    end

    assign bus.out_valid   = (count_q != '0);
    assign bus.out_op      = mem_q[rd_ptr_q].op;
    assign bus.out_rs1     = mem_q[rd_ptr_q].rs1;
    assign bus.out_rs2     = mem_q[rd_ptr_q].rs2;
    assign bus.out_rd      = mem_q[rd_ptr_q].rd;
    assign bus.out_func    = mem_q[rd_ptr_q].func;
    assign bus.out_imm     = mem_q[rd_ptr_q].imm;
    assign bus.out_pc      = mem_q[rd_ptr_q].pc;
    assign bus.out_illegal = mem_q[rd_ptr_q].illegal;
    assign cnt_instr       = cnt_instr_q;
    assign cnt_illegal     = cnt_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios, then random traffic scored against
// a queue-based reference; one instance with RV32M, one without and 4-bit counters.
module tb_decode_stage;

    localparam int DEPTH = 2;
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                        7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] cnt_i_m, cnt_l_m;
    logic [3:0]  cnt_i_n, cnt_l_n;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage_if bm ();
    decode_stage_if bn ();

    assign bm.in_valid  = in_valid;
    assign bm.in_instr  = in_instr;
    assign bm.in_pc     = in_pc;
    assign bm.out_ready = out_ready;
    assign bn.in_valid  = in_valid;
    assign bn.in_instr  = in_instr;
    assign bn.in_pc     = in_pc;
    assign bn.out_ready = out_ready;

    decode_stage #(.EN_M(1'b1), .DEPTH(DEPTH), .CNT_W(32)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bm.slave),
        .cnt_instr(cnt_i_m), .cnt_illegal(cnt_l_m)
    );

    decode_stage #(.EN_M(1'b0), .DEPTH(DEPTH), .CNT_W(4)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bn.slave),
        .cnt_instr(cnt_i_n), .cnt_illegal(cnt_l_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  func;
        logic [31:0] imm;
        logic        ill;
    } ref_t;

    function automatic bit ref_legal(logic [31:0] w, bit en_m);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (w[6:0])
            7'h33: return f7 == 0 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5})
                          || (f7 == 7'h01 && en_m);
            7'h13: return (f3 == 1) ? (f7 == 0)
                        : (f3 == 5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
            7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'h67: return f3 == 0;
            7'h23: return f3 <= 2;
            7'h63: return !(f3 inside {3'd2, 3'd3});
            7'h37, 7'h17, 7'h6F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ref_t ref_dec(logic [31:0] w, bit en_m);
        ref_t r;
        byte  fmt;
        r = '{op: w[6:0], rs1: 0, rs2: 0, rd: 0, func: 0, imm: 0, ill: 1'b0};
        if (!ref_legal(w, en_m)) begin
            r.ill = 1'b1;
            return r;
        end
        case (w[6:0])
            7'h33:               fmt = "R";
            7'h13, 7'h03, 7'h67: fmt = "I";
            7'h23:               fmt = "S";
            7'h63:               fmt = "B";
            7'h37, 7'h17:        fmt = "U";
            default:             fmt = "J";
        endcase
        if (fmt inside {"R", "I", "S", "B"}) r.rs1 = w[19:15];
        if (fmt inside {"R", "S", "B"})      r.rs2 = w[24:20];
        if (fmt inside {"R", "I", "U", "J"}) r.rd  = w[11:7];
        if (fmt == "R" || (w[6:0] == 7'h13 && w[13:12] == 2'b01))
            r.func = {w[31:25], w[14:12]};
        else if (!(fmt inside {"U", "J"}))
            r.func = {7'd0, w[14:12]};
        case (fmt)
            "I": r.imm = 32'($signed(w[31:20]));
            "S": r.imm = 32'($signed({w[31:25], w[11:7]}));
            "B": r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
            "U": r.imm = 32'(w[31:12]) * 4096;
            "J": r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
            default: r.imm = 0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 10);
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 7) != 0) w[6:0] = OPS[k];
        return w;
    endfunction

    function automatic logic [31:0] addi_k(int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    task automatic push_one(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string t, input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] func,
                              input logic [31:0] imm, input logic ill, input logic [31:0] pc,
                              input ref_t r, input logic [31:0] pc_exp);
        check({t, "_op"},   64'(op),   64'(r.op));
        check({t, "_rs1"},  64'(rs1),  64'(r.rs1));
        check({t, "_rs2"},  64'(rs2),  64'(r.rs2));
        check({t, "_rd"},   64'(rd),   64'(r.rd));
        check({t, "_func"}, 64'(func), 64'(r.func));
        check({t, "_imm"},  64'(imm),  64'(r.imm));
        check({t, "_ill"},  64'(ill),  64'(r.ill));
        check({t, "_pc"},   64'(pc),   64'(pc_exp));
    endtask

    logic [31:0] q_w [$];
    logic [31:0] q_pc [$];
    int          mc_i, mc_l, nc_i, nc_l;
    bit          rdy_en, exp_rdy, push, pop;
    ref_t        rm, rn;

    initial begin
        // Reset state
        #3;
        check("rst_rdy_m", 64'(bm.in_ready), 64'(0));
        check("rst_vld_m", 64'(bm.out_valid), 64'(0));
        check("rst_vld_n", 64'(bn.out_valid), 64'(0));
        check("rst_cnt_m", 64'(cnt_i_m), 64'(0));
        check("rst_imm_m", 64'(bm.out_imm), 64'(0));
        check("rst_op_m",  64'(bm.out_op), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("rel_rdy_m", 64'(bm.in_ready), 64'(1));

        // Directed decode with the consumer always ready
        out_ready = 1'b1;
        push_one(32'h002081B3);
        check("add_vld",  64'(bm.out_valid), 64'(1));
        check("add_op",   64'(bm.out_op), 64'(7'h33));
        check("add_rs1",  64'(bm.out_rs1), 64'(1));
        check("add_rs2",  64'(bm.out_rs2), 64'(2));
        check("add_rd",   64'(bm.out_rd), 64'(3));
        check("add_func", 64'(bm.out_func), 64'(0));
        check("add_ill",  64'(bm.out_illegal), 64'(0));
        check("add_cnt",  64'(cnt_i_m), 64'(1));
        push_one(32'hFFF00093);
        check("addi_imm", 64'(bm.out_imm), 64'(32'hFFFF_FFFF));
        check("addi_rd",  64'(bm.out_rd), 64'(1));
        check("addi_rs2", 64'(bm.out_rs2), 64'(0));
        push_one(32'hFE208EE3);
        check("beq_imm",  64'(bm.out_imm), 64'(32'hFFFF_FFFC));
        check("beq_rd",   64'(bm.out_rd), 64'(0));
        push_one(32'h0020A423);
        check("sw_imm",   64'(bm.out_imm), 64'(8));
        check("sw_rd",    64'(bm.out_rd), 64'(0));
        check("sw_func",  64'(bm.out_func), 64'(10'b0000000010));
        push_one(32'h027302B3);
        check("mul_func_m", 64'(bm.out_func), 64'(10'b0000001000));
        check("mul_ill_m",  64'(bm.out_illegal), 64'(0));
        check("mul_ill_n",  64'(bn.out_illegal), 64'(1));
        check("mul_func_n", 64'(bn.out_func), 64'(0));
        check("mul_rs1_n",  64'(bn.out_rs1), 64'(0));
        check("mul_rd_n",   64'(bn.out_rd), 64'(0));
        check("mul_imm_n",  64'(bn.out_imm), 64'(0));
        check("mul_cil_n",  64'(cnt_l_n), 64'(1));
        check("mul_cil_m",  64'(cnt_l_m), 64'(0));
        @(posedge clk) #1;
        check("drain_vld", 64'(bm.out_valid), 64'(0));

        // Full FIFO backpressure and no out_ready -> in_ready path
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_k(1);
        @(posedge clk) #1;
        in_instr = addi_k(2);
        @(posedge clk) #1;
        check("full_rdy",  64'(bm.in_ready), 64'(0));
        check("full_head", 64'(bm.out_imm), 64'(1));
        in_instr = addi_k(3);
        @(posedge clk) #1;
        check("hold_rdy",  64'(bm.in_ready), 64'(0));
        check("hold_head", 64'(bm.out_imm), 64'(1));
        out_ready = 1'b1;
        #1;
        check("fullpop_rdy", 64'(bm.in_ready), 64'(0));
        @(posedge clk) #1;
        check("ord_2",     64'(bm.out_imm), 64'(2));
        check("ord_2_rdy", 64'(bm.in_ready), 64'(1));
        @(posedge clk) #1;
        check("ord_3", 64'(bm.out_imm), 64'(3));
        in_valid = 1'b0;
        @(posedge clk) #1;
        check("ord_empty", 64'(bm.out_valid), 64'(0));
        check("ord_cnt",   64'(cnt_i_m), 64'(8));

        // Flush with a held input
        out_ready = 1'b0;
        push_one(addi_k(4));
        push_one(addi_k(5));
        in_valid = 1'b1;
        in_instr = addi_k(6);
        flush    = 1'b1;
        #1;
        check("flush_rdy", 64'(bm.in_ready), 64'(0));
        @(posedge clk) #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_vld",   64'(bm.out_valid), 64'(0));
        check("flush_cnt_m", 64'(cnt_i_m), 64'(10));
        check("flush_cnt_n", 64'(cnt_i_n), 64'(10));
        @(posedge clk) #1;
        check("flush_noacc", 64'(bm.out_valid), 64'(0));

        // Illegal words, then reset mid-stream
        push_one(32'h0000000F);
        check("fence_ill", 64'(bm.out_illegal), 64'(1));
        check("fence_op",  64'(bm.out_op), 64'(7'h0F));
        check("fence_imm", 64'(bm.out_imm), 64'(0));
        push_one(32'h00000000);
        check("zero_cil_m", 64'(cnt_l_m), 64'(2));
        check("zero_cil_n", 64'(cnt_l_n), 64'(3));
        check("zero_cnt_m", 64'(cnt_i_m), 64'(12));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 64'(bm.out_valid), 64'(0));
        check("arst_cnt", 64'(cnt_i_m), 64'(0));
        check("arst_cil", 64'(cnt_l_n), 64'(0));
        check("arst_rdy", 64'(bm.in_ready), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Random traffic against the queue model
        mc_i = 0; mc_l = 0; nc_i = 0; nc_l = 0;
        rdy_en = 1'b0;
        @(posedge clk) #1;
        rdy_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            exp_rdy = rdy_en && (q_w.size() < DEPTH) && !flush;
            check("r_rdy_m", 64'(bm.in_ready), 64'(exp_rdy));
            check("r_rdy_n", 64'(bn.in_ready), 64'(exp_rdy));
            check("r_vld_m", 64'(bm.out_valid), 64'(q_w.size() > 0));
            check("r_vld_n", 64'(bn.out_valid), 64'(q_w.size() > 0));
            check("r_ci_m",  64'(cnt_i_m), 64'(mc_i));
            check("r_cl_m",  64'(cnt_l_m), 64'(mc_l));
            check("r_ci_n",  64'(cnt_i_n), 64'(nc_i));
            check("r_cl_n",  64'(cnt_l_n), 64'(nc_l));
            if (q_w.size() > 0) begin
                rm = ref_dec(q_w[0], 1'b1);
                rn = ref_dec(q_w[0], 1'b0);
                check_head("r_m", bm.out_op, bm.out_rs1, bm.out_rs2, bm.out_rd, bm.out_func,
                           bm.out_imm, bm.out_illegal, bm.out_pc, rm, q_pc[0]);
                check_head("r_n", bn.out_op, bn.out_rs1, bn.out_rs2, bn.out_rd, bn.out_func,
                           bn.out_imm, bn.out_illegal, bn.out_pc, rn, q_pc[0]);
            end
            @(posedge clk);
            push = in_valid && exp_rdy;
            pop  = (q_w.size() > 0) && out_ready;
            if (flush) begin
                q_w.delete();
                q_pc.delete();
            end else begin
                if (pop) begin
                    void'(q_w.pop_front());
                    void'(q_pc.pop_front());
                end
                if (push) begin
                    q_w.push_back(in_instr);
                    q_pc.push_back(in_pc);
                end
            end
            if (push) begin
                mc_i++;
                if (!ref_legal(in_instr, 1'b1)) mc_l++;
                if (nc_i < 15) nc_i++;
                if (!ref_legal(in_instr, 1'b0) && nc_l < 15) nc_l++;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
